// File: rtl/avalon_multi_timer_pkg.sv
// Shared register-map constants for the multi-channel interval timer.
// Word offsets within a channel block and bit positions in STATUS/CONTROL.
package avalon_multi_timer_pkg;

  localparam logic [1:0] OFF_STATUS  = 2'd0;
  localparam logic [1:0] OFF_CONTROL = 2'd1;
  localparam logic [1:0] OFF_PERIOD  = 2'd2;
  localparam logic [1:0] OFF_SNAP    = 2'd3;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: down-counter, PERIOD, CONTROL, SNAP, TO and RUN.
// Interrupt is registered from the next-state so it tracks TO exactly.
module timer_channel
  import avalon_multi_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we_status,
  input  logic             we_control,
  input  logic             we_period,
  input  logic             we_snap,
  input  logic [31:0]      writedata,
  input  logic             tick,
  output logic             to,
  output logic             run,
  output logic             ito,
  output logic             cont,
  output logic             irq,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap
);

  localparam logic [CNT_W-1:0] RST_P = CNT_W'(RESET_PERIOD);

  logic [CNT_W-1:0] count, count_n;
  logic             run_n, to_n, ito_n, cont_n;
  logic             reload, start;

  assign start = we_control & writedata[CTL_START];

  always_comb begin
    count_n = count;
    run_n   = run;
    to_n    = to;
    ito_n   = ito;
    cont_n  = cont;
    if (we_status) to_n = 1'b0;
    if (we_control) begin
      ito_n  = writedata[CTL_ITO];
      cont_n = writedata[CTL_CONT];
      if (writedata[CTL_STOP]) run_n = 1'b0;
      if (start) run_n = 1'b1;
    end
    // a pending reload wins over counting; a START alongside it restarts
    if (reload) begin
      count_n = period;
      run_n   = start;
    end else if (run && tick && count == '0) begin
      count_n = period;
      to_n    = 1'b1;
      if (!cont && !start) run_n = 1'b0;
    end else if (run && tick) begin
      count_n = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= RST_P;
      period <= RST_P;
      snap   <= '0;
      run    <= 1'b0;
      to     <= 1'b0;
      ito    <= 1'b0;
      cont   <= 1'b0;
      irq    <= 1'b0;
      reload <= 1'b0;
    end else begin
      count  <= count_n;
      run    <= run_n;
      to     <= to_n;
      ito    <= ito_n;
      cont   <= cont_n;
      irq    <= to_n & ito_n;
      reload <= we_period;
      if (we_period) period <= writedata[CNT_W-1:0];
      if (we_snap) snap <= count;
    end
  end

endmodule

// File: rtl/avalon_multi_timer.sv
// N-channel interval timer behind an Avalon-MM slave port.
// Shared prescaler, address decode, registered read mux and IRQ OR.
module avalon_multi_timer
  import avalon_multi_timer_pkg::*;
#(
  parameter int   NUM_CH       = 4,
  parameter int   CNT_W        = 32,
  parameter int   PRESCALE_W   = 16,
  parameter int   RESET_PERIOD = 49999,
  localparam int  ADDR_W       = $clog2(NUM_CH*4+2)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_ch
);

  localparam logic [ADDR_W-1:0] A_PEND = ADDR_W'(4*NUM_CH);
  localparam logic [ADDR_W-1:0] A_PRE  = ADDR_W'(4*NUM_CH+1);

  logic              wr, we_pre, pre_load, tick;
  logic [ADDR_W-3:0] sel;
  logic [1:0]        off;
  logic [PRESCALE_W-1:0] prescale, pcnt;
  logic [31:0]       rdata;

  logic [NUM_CH-1:0] to, run, ito, cont;
  logic [CNT_W-1:0]  period [NUM_CH];
  logic [CNT_W-1:0]  snap   [NUM_CH];

  assign wr     = chipselect & ~write_n;
  assign sel    = address[ADDR_W-1:2];
  assign off    = address[1:0];
  assign we_pre = wr && address == A_PRE;
  assign tick   = pcnt == '0;
  assign irq    = |irq_ch;

  // the new PRESCALE takes effect one clock after it is written
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale <= '0;
      pre_load <= 1'b0;
      pcnt     <= '0;
    end else begin
      pre_load <= we_pre;
      if (we_pre) prescale <= writedata[PRESCALE_W-1:0];
      if (pre_load || pcnt == '0) pcnt <= prescale;
      else pcnt <= pcnt - PRESCALE_W'(1);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [ADDR_W-3:0] IDX = (ADDR_W-2)'(c);
    logic hit;
    assign hit = wr && sel == IDX;

    timer_channel #(
      .CNT_W        (CNT_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .we_status  (hit && off == OFF_STATUS),
      .we_control (hit && off == OFF_CONTROL),
      .we_period  (hit && off == OFF_PERIOD),
      .we_snap    (hit && off == OFF_SNAP),
      .writedata  (writedata),
      .tick       (tick),
      .to         (to[c]),
      .run        (run[c]),
      .ito        (ito[c]),
      .cont       (cont[c]),
      .irq        (irq_ch[c]),
      .period     (period[c]),
      .snap       (snap[c])
    );
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(sel) == c) begin
        case (off)
          OFF_STATUS: begin
            rdata[ST_TO]  = to[c];
            rdata[ST_RUN] = run[c];
          end
          OFF_CONTROL: begin
            rdata[CTL_ITO]  = ito[c];
            rdata[CTL_CONT] = cont[c];
          end
          OFF_PERIOD: rdata = 32'(period[c]);
          OFF_SNAP:   rdata = 32'(snap[c]);
          default:    rdata = '0;
        endcase
      end
    end
    if (address == A_PEND) rdata = 32'(irq_ch);
    if (address == A_PRE)  rdata = 32'(prescale);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else readdata <= rdata;
  end

endmodule
